enemy_formation: RTL and testbench
==================================

# enemy_formation

Holds the position and alive state of the eight-enemy invader row, marches the formation across the screen once per configurable number of frames, and drops it one rank at each edge. For every incoming pixel coordinate, it produces the packed per-enemy 12-bit sprite-ROM addresses and a one-hot read-enable. These feed the enemy sprite address multiplexer directly downstream.

## Interface

Parameters:

- `SPR_W`, 64: sprite width in px; must be 64, because the address is row*64+col in 12 bits.
- `SPR_H`, 64: sprite height in px.
- `SPACING`, 72: x distance between adjacent enemies; must be ≥ `SPR_W`.
- `START_X`, 32: reset value of base_x.
- `START_Y`, 40: reset value of base_y.
- `STEP`, 2: horizontal px per move.
- `DROP`, 16: vertical px per edge turn.
- `MOVE_DIV`, 4: frame_ticks per move.
- `LEFT_BOUND`, 0: left screen limit.
- `RIGHT_BOUND`, 640: right screen limit.
- `FLOOR_Y`, 480: invasion line.

Ports (one clock; reset is synchronous and active-high):

- `clk`, in, 1: system clock.
- `rst`, in, 1: synchronous, active-high reset.
- `frame_tick`, in, 1: one-cycle pulse per video frame.
- `pix_valid`, in, 1: the current pixel is in the active area.
- `pix_x`, in, 11: current pixel column.
- `pix_y`, in, 10: current pixel row.
- `kill`, in, 8: bit i pulse kills enemy i.
- `addr_out`, out, 96: enemy i address in bits [12i+11:12i].
- `rden`, out, 8: one-hot enable for the enemy hit by the pixel, or 0 when no enemy is hit.
- `alive`, out, 8: alive mask.
- `invaded`, out, 1: the formation has reached `FLOOR_Y`; sticky.
- `all_dead`, out, 1: `alive` == 0.

## Operation

- **Geometry:**
  - x_i = base_x + i*`SPACING`, for i = 0..7.
  - Every enemy shares y = base_y.
  - span = 7*`SPACING` + `SPR_W`.
  - Edge bounds use span regardless of `alive`.
- **Movement state machine:** states are RIGHT, LEFT and HALT.
  - The divider counts frame_ticks from 0 to `MOVE_DIV`-1 and wraps. A move-step occurs on the frame_tick where the count equals `MOVE_DIV`-1.
  - RIGHT move-step: if base_x + span + `STEP` > `RIGHT_BOUND`, then base_y += `DROP`, the state goes to LEFT, and base_x is unchanged. Otherwise base_x += `STEP`.
  - LEFT move-step: if base_x < `LEFT_BOUND` + `STEP`, then base_y += `DROP`, the state goes to RIGHT, and base_x is unchanged. Otherwise base_x -= `STEP`.
  - After any drop, if new base_y + `SPR_H` ≥ `FLOOR_Y`, the state goes to HALT and `invaded` is set.
  - When `all_dead` rises, the state goes to HALT.
  - HALT is exited only by `rst`. In HALT, frame_tick is ignored.
- **Kill:**
  - `kill[i]` clears alive[i] on the next edge.
  - Multiple bits may be set at once; every set bit is cleared.
  - Kills are accepted in every state, including HALT.
  - Killing an already-dead enemy has no effect.
- **Pixel lookup:**
  - Enemy i is hit when all of the following hold: `pix_valid`; alive[i]; x_i ≤ `pix_x` < x_i + `SPR_W`; base_y ≤ `pix_y` < base_y + `SPR_H`.
  - For a hit enemy, the address is (`pix_y` − base_y)[5:0]*64 + (`pix_x` − x_i)[5:0].
  - Non-hit address lanes are 0.
  - rden[i] = hit_i. At most one bit is set, guaranteed by `SPACING` ≥ `SPR_W`. If several bits were set, the lowest index wins.
- **Arithmetic:**
  - Comparisons use 12-bit unsigned extended operands, so that x_i + `SPR_W` does not wrap.
  - Hits are not clipped against the screen.

## Timing

- **Reset values:**
  - `addr_out` = 0, `rden` = 0.
  - `alive` = 8'hFF, `invaded` = 0, `all_dead` = 0.
  - base_x = `START_X`, base_y = `START_Y`, state = RIGHT, divider = 0.
- **Pixel lookup latency:** 1 cycle from `pix_x`/`pix_y`/`pix_valid` to registered `addr_out`/`rden`. The lookup uses the base_x/base_y/alive values present before the same edge.
- **Move-step:** base_x/base_y update on the clock edge that samples `frame_tick`.
- **Kill same cycle as frame_tick:** both the kill and the move are applied on the same edge.
- **`all_dead`:** asserted one cycle after the final kill.
- **Downstream hold:** when `rden` = 0, the downstream multiplexer holds its last address. This block does not need to hold.
- **Reset mid-march:** `rst` wins over `kill` and `frame_tick` in the same cycle.

## Test plan

- **Reset:** assert `rst`, then release. Check `alive` = FF, `rden` = 0, `addr_out` = 0. Drive `pix_x`=40, `pix_y`=45 with `pix_valid`=1; one cycle later expect `rden` = 01 and lane 0 = 5*64+8 = 328.
- **Pixel hit on enemy 2:** drive `pix_x`=181, `pix_y`=43, `pix_valid`=1. Next cycle expect `rden` = 8'b00000100, `addr_out[35:24]` = 197, and all other lanes 0. With `pix_valid`=0, expect `rden` = 0.
- **Kill:** pulse `kill` = 8'b00000100, then repeat the enemy-2 hit. Expect `rden` = 0 and `alive` = FB. Pulse `kill` = 04 together with `frame_tick`; both take effect on that edge.
- **Right-edge drop:** issue 80 frame_ticks (20 moves). Expect base_x = 72; check via the enemy-0 hit at `pix_x`=72, `pix_y`=40, where `addr_out[11:0]` = 0. Issue 4 more frame_ticks. Expect base_y = 56 and base_x = 72 unchanged. The next move-step gives base_x = 70.
- **Invasion:** march until the 24th drop, when base_y = 424. Expect `invaded` = 1 on that edge. Further frame_ticks leave the positions frozen.
- **All dead:** pulse `kill` = FF. The next cycle gives `alive` = 0 and `all_dead` = 1, and every pixel gives `rden` = 0. Subsequent frame_ticks leave the positions unchanged.

Source files
------------

// File: rtl/enemy_formation.sv
// enemy_formation
// Eight-enemy invader row: position, alive mask and march state machine,
// plus a registered per-pixel sprite-ROM address lookup.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   frame_tick      - one-cycle pulse per video frame
//   pix_valid       - current pixel is in the active area
//   pix_x, pix_y    - current pixel coordinate
//   kill[7:0]       - bit i pulse clears alive[i]
//   addr_out[95:0]  - enemy i sprite address in bits [12i+11:12i] (0 when not hit)
//   rden[7:0]       - one-hot enable of the enemy hit by the pixel, else 0
//   alive[7:0]      - alive mask
//   invaded         - formation reached FLOOR_Y (sticky)
//   all_dead        - alive == 0
module enemy_formation #(
    parameter int SPR_W       = 64,
    parameter int SPR_H       = 64,
    parameter int SPACING     = 72,
    parameter int START_X     = 32,
    parameter int START_Y     = 40,
    parameter int STEP        = 2,
    parameter int DROP        = 16,
    parameter int MOVE_DIV    = 4,
    parameter int LEFT_BOUND  = 0,
    parameter int RIGHT_BOUND = 640,
    parameter int FLOOR_Y     = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        pix_valid,
    input  logic [10:0] pix_x,
    input  logic [9:0]  pix_y,
    input  logic [7:0]  kill,
    output logic [95:0] addr_out,
    output logic [7:0]  rden,
    output logic [7:0]  alive,
    output logic        invaded,
    output logic        all_dead
);

    localparam int NUM_EN = 8;

    // All geometry is done in 12-bit unsigned so x_i + SPR_W never wraps.
    localparam logic [11:0] SPAN_W   = 12'((NUM_EN - 1) * SPACING + SPR_W);
    localparam logic [11:0] STEP_W   = 12'(STEP);
    localparam logic [11:0] DROP_W   = 12'(DROP);
    localparam logic [11:0] SPRW_W   = 12'(SPR_W);
    localparam logic [11:0] SPRH_W   = 12'(SPR_H);
    localparam logic [11:0] RB_W     = 12'(RIGHT_BOUND);
    localparam logic [11:0] LB_W     = 12'(LEFT_BOUND);
    localparam logic [11:0] FLOOR_W  = 12'(FLOOR_Y);
    localparam logic [15:0] DIV_LAST = 16'(MOVE_DIV - 1);

    typedef enum logic [1:0] {S_RIGHT, S_LEFT, S_HALT} state_t;

    state_t      state, state_nx;
    logic [11:0] base_x, base_x_nx;
    logic [11:0] base_y, base_y_nx;
    logic [15:0] div_cnt, div_nx;
    logic [7:0]  alive_nx;
    logic        invaded_nx;
    logic        march;
    logic        step;
    logic [11:0] drop_y;

    assign all_dead = (alive == 8'h00);

    // ---------------- movement FSM: next state ----------------
    always_comb begin
        state_nx   = state;
        base_x_nx  = base_x;
        base_y_nx  = base_y;
        div_nx     = div_cnt;
        invaded_nx = invaded;
        alive_nx   = alive & ~kill;
        drop_y     = base_y + DROP_W;

        // A fully dead formation stops marching at once, even before HALT lands.
        march = frame_tick && (state != S_HALT) && !all_dead;
        step  = march && (div_cnt == DIV_LAST);

        if (march)
            div_nx = (div_cnt == DIV_LAST) ? 16'd0 : div_cnt + 16'd1;

        if (step) begin
            if (state == S_RIGHT) begin
                if (base_x + SPAN_W + STEP_W > RB_W) begin
                    base_y_nx = drop_y;
                    state_nx  = S_LEFT;
                end else begin
                    base_x_nx = base_x + STEP_W;
                end
            end else begin
                if (base_x < LB_W + STEP_W) begin
                    base_y_nx = drop_y;
                    state_nx  = S_RIGHT;
                end else begin
                    base_x_nx = base_x - STEP_W;
                end
            end
            // Only a drop changes base_y, so this check is the post-drop test.
            if (base_y_nx != base_y && base_y_nx + SPRH_W >= FLOOR_W) begin
                state_nx   = S_HALT;
                invaded_nx = 1'b1;
            end
        end

        if (all_dead)
            state_nx = S_HALT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_RIGHT;
            base_x  <= 12'(START_X);
            base_y  <= 12'(START_Y);
            div_cnt <= 16'd0;
            alive   <= 8'hFF;
            invaded <= 1'b0;
        end else begin
            state   <= state_nx;
            base_x  <= base_x_nx;
            base_y  <= base_y_nx;
            div_cnt <= div_nx;
            alive   <= alive_nx;
            invaded <= invaded_nx;
        end
    end

    // ---------------- pixel lookup ----------------
    logic [11:0]              px, py;
    logic [NUM_EN-1:0]        hit;
    logic [NUM_EN-1:0][11:0]  lane_addr;
    logic [NUM_EN-1:0]        rden_nx;
    logic [95:0]              addr_nx;

    assign px = {1'b0, pix_x};
    assign py = {2'b00, pix_y};

    for (genvar i = 0; i < NUM_EN; i++) begin : g_lane
        logic [11:0] xi, dx, dy;
        assign xi = base_x + 12'(i * SPACING);
        assign dx = px - xi;
        assign dy = py - base_y;
        assign hit[i] = pix_valid && alive[i] &&
                        (px >= xi) && (px < xi + SPRW_W) &&
                        (py >= base_y) && (py < base_y + SPRH_W);
        assign lane_addr[i] = {dy[5:0], dx[5:0]};
    end

    // Lowest index wins should overlapping sprites ever hit together.
    always_comb begin
        rden_nx = '0;
        addr_nx = '0;
        for (int i = NUM_EN - 1; i >= 0; i--) begin
            if (hit[i]) begin
                rden_nx = '0;
                addr_nx = '0;
                rden_nx[i] = 1'b1;
                addr_nx[12*i +: 12] = lane_addr[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rden     <= '0;
            addr_out <= '0;
        end else begin
            rden     <= rden_nx;
            addr_out <= addr_nx;
        end
    end

endmodule

// File: tb/tb_enemy_formation.sv
module tb_enemy_formation;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic        pix_valid;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic [7:0]  kill;
    logic [95:0] addr_out;
    logic [7:0]  rden;
    logic [7:0]  alive;
    logic        invaded;
    logic        all_dead;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    enemy_formation dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .pix_valid(pix_valid),
        .pix_x(pix_x), .pix_y(pix_y), .kill(kill), .addr_out(addr_out),
        .rden(rden), .alive(alive), .invaded(invaded), .all_dead(all_dead)
    );

    // Inputs change #1 after a rising edge; outputs are sampled there too.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; frame_tick = 1'b0; pix_valid = 1'b0; kill = 8'h00;
        pix_x = '0; pix_y = '0;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
            cyc();
        end
    endtask

    task automatic lookup(input int x, input int y);
        pix_x = 11'(x); pix_y = 10'(y); pix_valid = 1'b1;
        cyc();
        pix_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (alive !== 8'hFF) begin errors++; $display("FAIL reset_alive got %h exp FF", alive); end
        checks++; if (rden !== 8'h00 || addr_out !== 96'd0) begin errors++; $display("FAIL reset_out rden %h addr %h exp 0", rden, addr_out); end
        checks++; if (invaded !== 1'b0 || all_dead !== 1'b0) begin errors++; $display("FAIL reset_flags inv %b dead %b exp 0 0", invaded, all_dead); end
        lookup(40, 45);
        checks++; if (rden !== 8'h01 || addr_out !== 96'd328) begin errors++; $display("FAIL reset_hit0 rden %h addr %h exp 01 328", rden, addr_out); end
    endtask

    task automatic test_pixel_hit();
        logic [95:0] exp_a;
        exp_a = 96'd0; exp_a[35:24] = 12'd197;
        lookup(181, 43);
        checks++; if (rden !== 8'h04 || addr_out !== exp_a) begin errors++; $display("FAIL hit2 rden %h addr %h exp 04 %h", rden, addr_out, exp_a); end
        pix_x = 11'd181; pix_y = 10'd43; pix_valid = 1'b0;
        cyc();
        checks++; if (rden !== 8'h00 || addr_out !== 96'd0) begin errors++; $display("FAIL novalid rden %h addr %h exp 0", rden, addr_out); end
        lookup(240, 43);   // just right of enemy 2, left of enemy 3
        checks++; if (rden !== 8'h00) begin errors++; $display("FAIL gap_x rden %h exp 00", rden); end
        lookup(239, 103);  // last pixel of enemy 2: row 63 col 63
        checks++; if (rden !== 8'h04 || addr_out[35:24] !== 12'd4095) begin errors++; $display("FAIL corner2 rden %h addr %0d exp 04 4095", rden, addr_out[35:24]); end
        lookup(181, 104);  // one row below sprite
        checks++; if (rden !== 8'h00) begin errors++; $display("FAIL below_y rden %h exp 00", rden); end
        lookup(536, 40);   // enemy 7 origin: 32 + 7*72
        checks++; if (rden !== 8'h80 || addr_out[95:84] !== 12'd0) begin errors++; $display("FAIL hit7 rden %h addr %0d exp 80 0", rden, addr_out[95:84]); end
    endtask

    task automatic test_kill();
        kill = 8'h04; cyc(); kill = 8'h00;
        checks++; if (alive !== 8'hFB) begin errors++; $display("FAIL kill_alive got %h exp FB", alive); end
        lookup(181, 43);
        checks++; if (rden !== 8'h00) begin errors++; $display("FAIL kill_hit rden %h exp 00", rden); end
        // Kill together with the move-step frame_tick (the 4th).
        ticks(3);
        kill = 8'h0C; frame_tick = 1'b1; cyc(); kill = 8'h00; frame_tick = 1'b0;
        checks++; if (alive !== 8'hF3) begin errors++; $display("FAIL kill_tick_alive got %h exp F3", alive); end
        lookup(34, 40);
        checks++; if (rden !== 8'h01 || addr_out[11:0] !== 12'd0) begin errors++; $display("FAIL kill_tick_move rden %h addr %0d exp 01 0", rden, addr_out[11:0]); end
    endtask

    task automatic test_right_edge();
        do_reset();
        ticks(80);
        lookup(72, 40);
        checks++; if (rden !== 8'h01 || addr_out[11:0] !== 12'd0) begin errors++; $display("FAIL edge72 rden %h addr %0d exp 01 0", rden, addr_out[11:0]); end
        lookup(71, 40);
        checks++; if (rden !== 8'h00) begin errors++; $display("FAIL edge71 rden %h exp 00", rden); end
        ticks(4);
        lookup(72, 56);
        checks++; if (rden !== 8'h01 || addr_out[11:0] !== 12'd0) begin errors++; $display("FAIL drop56 rden %h addr %0d exp 01 0", rden, addr_out[11:0]); end
        lookup(72, 55);
        checks++; if (rden !== 8'h00) begin errors++; $display("FAIL drop55 rden %h exp 00", rden); end
        ticks(4);
        lookup(70, 56);
        checks++; if (rden !== 8'h01 || addr_out[11:0] !== 12'd0) begin errors++; $display("FAIL left70 rden %h addr %0d exp 01 0", rden, addr_out[11:0]); end
    endtask

    task automatic test_invasion();
        do_reset();
        ticks(871 * 4);    // last move before the 24th drop: base_x 0, base_y 408
        checks++; if (invaded !== 1'b0) begin errors++; $display("FAIL preinv invaded %b exp 0", invaded); end
        lookup(0, 408);
        checks++; if (rden !== 8'h01 || addr_out[11:0] !== 12'd0) begin errors++; $display("FAIL preinv_pos rden %h addr %0d exp 01 0", rden, addr_out[11:0]); end
        ticks(3);
        frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
        checks++; if (invaded !== 1'b1) begin errors++; $display("FAIL invaded got %b exp 1", invaded); end
        ticks(8);
        lookup(5, 426);
        checks++; if (rden !== 8'h01 || addr_out[11:0] !== 12'd133) begin errors++; $display("FAIL frozen rden %h addr %0d exp 01 133", rden, addr_out[11:0]); end
        // Kills still accepted while halted.
        kill = 8'hFE; cyc(); kill = 8'h00;
        checks++; if (alive !== 8'h01 || invaded !== 1'b1) begin errors++; $display("FAIL halt_kill alive %h inv %b exp 01 1", alive, invaded); end
    endtask

    task automatic test_all_dead();
        do_reset();
        kill = 8'hFF; cyc(); kill = 8'h00;
        checks++; if (alive !== 8'h00 || all_dead !== 1'b1) begin errors++; $display("FAIL alldead alive %h dead %b exp 00 1", alive, all_dead); end
        lookup(40, 45);
        checks++; if (rden !== 8'h00 || addr_out !== 96'd0) begin errors++; $display("FAIL alldead_hit rden %h addr %h exp 0", rden, addr_out); end
        ticks(8);
        kill = 8'h01; cyc(); kill = 8'h00;
        checks++; if (alive !== 8'h00 || all_dead !== 1'b1 || invaded !== 1'b0) begin errors++; $display("FAIL alldead_stay alive %h dead %b inv %b exp 00 1 0", alive, all_dead, invaded); end
    endtask

    task automatic test_reset_priority();
        rst = 1'b1; kill = 8'hFF; frame_tick = 1'b1;
        cyc();
        rst = 1'b0; kill = 8'h00; frame_tick = 1'b0;
        checks++; if (alive !== 8'hFF || all_dead !== 1'b0) begin errors++; $display("FAIL rst_prio alive %h dead %b exp FF 0", alive, all_dead); end
        lookup(32, 40);
        checks++; if (rden !== 8'h01 || addr_out[11:0] !== 12'd0) begin errors++; $display("FAIL rst_prio_pos rden %h addr %0d exp 01 0", rden, addr_out[11:0]); end
    endtask

    initial begin
        test_reset();
        test_pixel_hit();
        test_kill();
        test_right_edge();
        test_invasion();
        test_all_dead();
        test_reset_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
